// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: receiver state encoding, frame geometry,
// default watchdog length for a 50 MHz system clock, and common scan-code prefixes.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int FRAME_BITS = 11;

   // 1 ms at 50 MHz; well beyond the slowest legal PS/2 bit period.
   localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

   localparam logic [7:0] BREAK_PREFIX = 8'hF0;
   localparam logic [7:0] EXT_PREFIX   = 8'hE0;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous show-ahead FIFO: head_data always presents the oldest entry.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ps2_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A push into a full queue is still accepted when a pop frees a slot this cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 keyboard front end: synchronise and deglitch the pads,
// deserialise 11-bit frames, and queue good scan codes behind a valid/ready port.
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic       overflow,
   input  logic       clr_overflow,
   output logic       frame_err,
   output logic       busy
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]             rst_pipe;
   logic                   rst_sync_n;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_s;
   logic                   dat_s;
   logic                   clk_filt;
   logic [FCW-1:0]         filt_cnt;
   logic                   fall_edge;
   rx_state_t              state;
   rx_state_t              state_next;
   logic [7:0]             shift_reg;
   logic [2:0]             bit_cnt;
   logic                   parity_bit;
   logic [TCW-1:0]         idle_cnt;
   logic                   timeout;
   logic                   frame_ok;
   logic                   push_c;
   logic                   err_c;
   logic                   pop_c;
   logic                   fifo_full;
   logic                   fifo_empty;

   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) rst_pipe <= '0;
      else          rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_sync_n = rst_pipe[1];

   // Idle PS/2 lines are high, so the synchronisers reset to 1.
   always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         clk_sync <= '1;
         dat_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
      end
   end
   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign dat_s = dat_sync[SYNC_STAGES-1];

   always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         clk_filt  <= 1'b1;
         filt_cnt  <= '0;
         fall_edge <= 1'b0;
      end else begin
         fall_edge <= 1'b0;
         if (clk_s == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
            clk_filt  <= clk_s;
            filt_cnt  <= '0;
            fall_edge <= clk_filt;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   // A real edge in the same cycle takes priority over the watchdog.
   assign timeout  = (state != IDLE) && !fall_edge && (idle_cnt == TCW'(TIMEOUT_CYCLES - 1));
   assign frame_ok = ((^shift_reg) ^ parity_bit) & dat_s;

   always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
      if (!rst_sync_n) state <= IDLE;
      else             state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (fall_edge) begin
         case (state)
            IDLE:    if (!dat_s) state_next = DATA;
            DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
            PARITY:  state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end else if (timeout) begin
         state_next = IDLE;
      end
   end

   always_comb begin
      push_c = 1'b0;
      err_c  = 1'b0;
      if (state == STOP && fall_edge) begin
         push_c = frame_ok;
         err_c  = !frame_ok;
      end
      if (timeout) err_c = 1'b1;
   end

   always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         shift_reg  <= '0;
         bit_cnt    <= '0;
         parity_bit <= 1'b0;
         idle_cnt   <= '0;
      end else begin
         if (fall_edge) begin
            case (state)
               IDLE:    bit_cnt <= '0;
               DATA: begin
                  shift_reg <= {dat_s, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 1'b1;
               end
               PARITY:  parity_bit <= dat_s;
               default: ;
            endcase
         end
         if (fall_edge || state == IDLE || timeout) idle_cnt <= '0;
         else                                       idle_cnt <= idle_cnt + 1'b1;
      end
   end

   assign pop_c = rd_ready && !fifo_empty;

   // A simultaneous set beats the clear.
   always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (push_c && fifo_full && !pop_c) overflow <= 1'b1;
         else if (clr_overflow)             overflow <= 1'b0;
         frame_err <= err_c;
         busy      <= (state_next != IDLE);
      end
   end

   ps2_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (CLOCK_50),
      .rst_n     (rst_sync_n),
      .push      (push_c),
      .push_data (shift_reg),
      .pop       (pop_c),
      .head_data (rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: drives PS/2 frames on the pads and
// compares the queue, flags and status against hand-computed values.
module tb_ps2_keyboard_rx;

   localparam int HALF    = 20;
   localparam int TIMEOUT = 200;

   logic       CLOCK_50;
   logic       RESET_N;
   logic       PS2_CLK;
   logic       PS2_DAT;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic       overflow;
   logic       clr_overflow;
   logic       frame_err;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;
   int busy_cycles = 0;
   int snap_err;
   int snap_busy;

   ps2_keyboard_rx #(
      .FIFO_DEPTH     (8),
      .SYNC_STAGES    (2),
      .FILTER_LEN     (4),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .RESET_N      (RESET_N),
      .PS2_CLK      (PS2_CLK),
      .PS2_DAT      (PS2_DAT),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      if (frame_err) err_pulses <= err_pulses + 1;
      if (busy)      busy_cycles <= busy_cycles + 1;
   end

   task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic drive_bit(input logic b);
      PS2_DAT = b;
      repeat (HALF) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
   endtask

   // Sends the first nbits of a frame: start, 8 data bits LSB first, parity, stop.
   task automatic apply_stimulus(input logic [7:0] data, input logic par, input logic stop, input int nbits);
      logic [10:0] bits;
      bits = {stop, par, data, 1'b0};
      for (int i = 0; i < nbits; i++) drive_bit(bits[i]);
   endtask

   task automatic pop_one();
      rd_ready = 1'b1;
      @(negedge CLOCK_50);
      rd_ready = 1'b0;
   endtask

   initial begin
      PS2_CLK      = 1'b1;
      PS2_DAT      = 1'b1;
      RESET_N      = 1'b0;
      rd_ready     = 1'b0;
      clr_overflow = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      check_output("rst_valid", {7'd0, rd_valid}, 8'h00);
      check_output("rst_data", rd_data, 8'h00);
      check_output("rst_overflow", {7'd0, overflow}, 8'h00);
      check_output("rst_frame_err", {7'd0, frame_err}, 8'h00);
      check_output("rst_busy", {7'd0, busy}, 8'h00);
      RESET_N = 1'b1;
      repeat (10) @(negedge CLOCK_50);

      $display("[TB] good frame 0x1C with latency check");
      snap_err = err_pulses;
      apply_stimulus(8'h1C, 1'b0, 1'b1, 10);
      PS2_DAT = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      repeat (6) @(negedge CLOCK_50);
      check_output("t1_valid_early", {7'd0, rd_valid}, 8'h00);
      @(negedge CLOCK_50);
      check_output("t1_valid", {7'd0, rd_valid}, 8'h01);
      check_output("t1_data", rd_data, 8'h1C);
      check_output("t1_busy", {7'd0, busy}, 8'h00);
      repeat (HALF - 7) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      check_output("t1_no_err", 8'(err_pulses - snap_err), 8'h00);
      pop_one();
      check_output("t1_drained", {7'd0, rd_valid}, 8'h00);

      $display("[TB] parity error then good frame 0x32");
      snap_err = err_pulses;
      apply_stimulus(8'h1C, 1'b1, 1'b1, 11);
      check_output("t2_err_pulses", 8'(err_pulses - snap_err), 8'h01);
      check_output("t2_valid", {7'd0, rd_valid}, 8'h00);
      apply_stimulus(8'h32, 1'b0, 1'b1, 11);
      check_output("t2_valid_32", {7'd0, rd_valid}, 8'h01);
      check_output("t2_data_32", rd_data, 8'h32);
      pop_one();

      $display("[TB] back-to-back F0 1C");
      apply_stimulus(8'hF0, 1'b1, 1'b1, 11);
      apply_stimulus(8'h1C, 1'b0, 1'b1, 11);
      check_output("t3_head", rd_data, 8'hF0);
      rd_ready = 1'b1;
      check_output("t3_pop0", rd_data, 8'hF0);
      @(negedge CLOCK_50);
      check_output("t3_pop1", rd_data, 8'h1C);
      check_output("t3_valid1", {7'd0, rd_valid}, 8'h01);
      @(negedge CLOCK_50);
      check_output("t3_empty", {7'd0, rd_valid}, 8'h00);
      @(negedge CLOCK_50);
      check_output("t3_pop_empty", {7'd0, rd_valid}, 8'h00);
      rd_ready = 1'b0;

      $display("[TB] overflow with nine frames");
      for (int i = 1; i <= 9; i++) apply_stimulus(8'(i), ~^(8'(i)), 1'b1, 11);
      check_output("t4_overflow", {7'd0, overflow}, 8'h01);
      check_output("t4_head", rd_data, 8'h01);
      repeat (10) @(negedge CLOCK_50);
      check_output("t4_sticky", {7'd0, overflow}, 8'h01);
      clr_overflow = 1'b1;
      @(negedge CLOCK_50);
      clr_overflow = 1'b0;
      check_output("t4_cleared", {7'd0, overflow}, 8'h00);
      apply_stimulus(8'h0A, 1'b1, 1'b1, 10);
      PS2_DAT = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      repeat (6) @(negedge CLOCK_50);
      rd_ready = 1'b1;
      @(negedge CLOCK_50);
      rd_ready = 1'b0;
      repeat (HALF - 7) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      check_output("t4_no_overflow", {7'd0, overflow}, 8'h00);
      for (int i = 0; i < 8; i++) begin
         check_output("t4_drain", rd_data, (i < 7) ? 8'(i + 2) : 8'h0A);
         pop_one();
      end
      check_output("t4_empty", {7'd0, rd_valid}, 8'h00);

      $display("[TB] truncated frame and watchdog");
      snap_err = err_pulses;
      apply_stimulus(8'h00, 1'b1, 1'b1, 4);
      check_output("t5_busy", {7'd0, busy}, 8'h01);
      repeat (TIMEOUT + 20) @(negedge CLOCK_50);
      check_output("t5_err", 8'(err_pulses - snap_err), 8'h01);
      check_output("t5_idle", {7'd0, busy}, 8'h00);
      check_output("t5_no_push", {7'd0, rd_valid}, 8'h00);
      apply_stimulus(8'h29, 1'b0, 1'b1, 11);
      check_output("t5_data_29", rd_data, 8'h29);
      pop_one();
      snap_err  = err_pulses;
      snap_busy = busy_cycles;
      PS2_DAT = 1'b0;
      repeat (10) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
      repeat (20) @(negedge CLOCK_50);
      check_output("t5_glitch_busy", 8'(busy_cycles - snap_busy), 8'h00);
      check_output("t5_glitch_err", 8'(err_pulses - snap_err), 8'h00);
      PS2_DAT = 1'b1;
      repeat (10) @(negedge CLOCK_50);

      $display("[TB] reset during data bit 5");
      apply_stimulus(8'h11, 1'b1, 1'b1, 11);
      check_output("t6_pre_valid", {7'd0, rd_valid}, 8'h01);
      apply_stimulus(8'h5A, 1'b1, 1'b1, 6);
      PS2_DAT = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      check_output("t6_busy_pre", {7'd0, busy}, 8'h01);
      RESET_N = 1'b0;
      #1;
      check_output("t6_rst_valid", {7'd0, rd_valid}, 8'h00);
      check_output("t6_rst_data", rd_data, 8'h00);
      check_output("t6_rst_busy", {7'd0, busy}, 8'h00);
      check_output("t6_rst_overflow", {7'd0, overflow}, 8'h00);
      check_output("t6_rst_err", {7'd0, frame_err}, 8'h00);
      @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      repeat (5) @(negedge CLOCK_50);
      RESET_N = 1'b1;
      repeat (10) @(negedge CLOCK_50);
      apply_stimulus(8'h5A, 1'b1, 1'b1, 11);
      check_output("t6_valid_5a", {7'd0, rd_valid}, 8'h01);
      check_output("t6_data_5a", rd_data, 8'h5A);
      pop_one();
      check_output("t6_empty", {7'd0, rd_valid}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Receive-only PS/2 keyboard front end that feeds the board top-level's application logic from the PS2_CLK/PS2_DAT pins.
- Synchronises and deglitches the PS/2 lines, then deserialises 11-bit device-to-host frames and checks start, odd parity and stop.
- Good scan codes are queued in a small show-ahead FIFO with a valid/ready read port. An idle watchdog recovers from truncated frames.
- The top-level keeps ownership of the inout pads; this block only samples them.

Parameters:
- FIFO_DEPTH, 8, scan-code queue depth; power of two, at least 2.
- SYNC_STAGES, 2, flip-flop synchroniser depth on each PS/2 line.
- FILTER_LEN, 4, consecutive identical synchronised samples needed to change the filtered PS2_CLK level.
- TIMEOUT_CYCLES, 50000, CLOCK_50 cycles without a filtered falling edge before an in-progress frame is abandoned (1 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- RESET_N  in  1  asynchronous active-low reset
- PS2_CLK  in  1  PS/2 clock pad value, asynchronous
- PS2_DAT  in  1  PS/2 data pad value, asynchronous
- rd_data  out  8  head-of-queue scan code; valid only when rd_valid=1
- rd_valid  out  1  queue non-empty
- rd_ready  in  1  consumer pops the head on a cycle where rd_valid & rd_ready
- overflow  out  1  sticky flag: a good frame was dropped because the queue was full
- clr_overflow  in  1  synchronous clear of overflow
- frame_err  out  1  one-cycle pulse on a parity, stop or timeout error
- busy  out  1  high while the receive state machine is not IDLE

Behaviour:
- Reset: all outputs 0, queue empty, state IDLE, filtered clock 1, counters 0. The reset is asynchronous assert and synchronous-safe deassert. Reset mid-frame discards the partial frame.
- Front end: both lines pass through SYNC_STAGES flops. The clock line then passes the FILTER_LEN equal-sample filter. fall_edge is a one-cycle pulse when the filtered clock goes 1->0. The data line is sampled from its synchroniser output on fall_edge.
- FSM, advancing only on fall_edge except for the timeout:
  - IDLE: data=0 -> DATA, bit count 0. data=1 -> stay in IDLE, no error.
  - DATA: shift right (LSB first) into an 8-bit register, count 0..7; after bit 7 -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: ok when the XOR of the 8 data bits and the parity bit is 1 and the stop bit is 1. On ok, push; otherwise pulse frame_err. Always -> IDLE.
- Timeout: an idle counter is cleared on every fall_edge and counts while the state is not IDLE. On reaching TIMEOUT_CYCLES-1: go to IDLE, pulse frame_err, no push.
- Push timing: the push is registered in the cycle of the STOP fall_edge. rd_valid/rd_data update the next cycle, so latency is 1 cycle after fall_edge.
- Pin-to-fall_edge latency is SYNC_STAGES+FILTER_LEN cycles.
- Queue: show-ahead, rd_data = entry at the head pointer. Pointers wrap modulo FIFO_DEPTH and use an extra bit for the full/empty distinction.
- Full and push with no pop: the new byte is dropped, overflow set, queue unchanged.
- Full and push with a pop in the same cycle: both happen, count unchanged, no overflow.
- Pop while empty: ignored; rd_ready is a don't-care when rd_valid=0.
- A set event and clr_overflow in the same cycle: set wins.
- A frame error never touches the queue or overflow.
- busy = (state != IDLE), registered.

Decomposition:
- Shared package ps2_pkg holds:
  - the rx state enum (IDLE, DATA, PARITY, STOP);
  - FRAME_BITS=11;
  - default TIMEOUT_CYCLES for 50 MHz;
  - common scan-code constants BREAK_PREFIX=8'hF0 and EXT_PREFIX=8'hE0, for downstream decoders.
- One sub-module, ps2_rx_fifo: parameterised synchronous show-ahead FIFO with push, pop, full, empty, and the same clock/reset.
- The synchroniser, filter and FSM stay in the top of this block.

Test Plan:
- Frame 0x1C (A make), parity 0, stop 1, bit period 80 us -> one cycle after the final fall_edge: rd_valid=1, rd_data=8'h1C, frame_err never asserted, busy back to 0.
- Frame 0x1C with parity 1 -> exactly one frame_err pulse, rd_valid stays 0, next good frame 0x32 is queued as 8'h32.
- Frames F0 then 1C back-to-back with rd_ready=0 -> queue holds 2. Raising rd_ready yields 8'hF0 then 8'h1C on consecutive cycles, then rd_valid=0.
- Nine good frames 0x01..0x09 with rd_ready=0, FIFO_DEPTH=8 -> 0x01..0x08 are retained, 0x09 is dropped, overflow=1. overflow stays 1 until clr_overflow pulses, then 0. A pop of 0x01 coinciding with a 10th push gives no overflow set.
- Four clock edges, then the line idles high for TIMEOUT_CYCLES -> frame_err pulse, busy=0. A following frame 0x29 is received correctly. A 2-cycle low glitch on PS2_CLK produces no fall_edge and no state change.
- RESET_N low during data bit 5 -> all outputs 0 within the same cycle, queue empty. After release, a full frame 0x5A is received correctly.
